bb_mem_responder: RTL and testbench
===================================

Name: bb_mem_responder

Overview:
- Memory-side responder for the black_bean memory port. It is the counterpart to mem_controller: it consumes mem_r_en/mem_r_addr and mem_w_en/mem_w_addr/mem_w_data, and returns mem_r_data.
- Contains a word-addressed RAM array with a configurable read-latency pipeline, write-first collision handling, out-of-range detection and access counters.
- Used as the memory model in the core testbench and as the on-chip RAM in FPGA builds.

Parameters:
- DATA_WIDTH, 16, word width of data and address buses; matches the core's DATA_WIDTH.
- ADDR_BITS, 10, implemented depth is 2**ADDR_BITS words.
- READ_LATENCY, 1, cycles from accepted read to mem_r_data valid; legal range 1..4.
- CNT_WIDTH, 16, width of the access counters.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mem_r_en  in  1  read request, sampled every cycle.
- mem_r_addr  in  DATA_WIDTH  read word address.
- mem_w_en  in  1  write request, sampled every cycle.
- mem_w_addr  in  DATA_WIDTH  write word address.
- mem_w_data  in  DATA_WIDTH  write data.
- mem_r_data  out  DATA_WIDTH  read data; holds its last value between valids.
- mem_r_valid  out  1  one-cycle pulse per returned read.
- addr_err  out  1  sticky flag; set by any out-of-range access.
- rd_count  out  CNT_WIDTH  accepted in-range reads, saturating.
- wr_count  out  CNT_WIDTH  accepted in-range writes, saturating.

Behaviour:
- Reset, asynchronous on rst=1:
  - Outputs: mem_r_data=0, mem_r_valid=0, addr_err=0, rd_count=0, wr_count=0.
  - All read-pipeline stages are cleared; reads in flight when rst asserts are dropped and produce no valid.
  - RAM contents are not reset.
- In-range test: an address is in range iff bits [DATA_WIDTH-1:ADDR_BITS] are all zero. The array index is bits [ADDR_BITS-1:0].
- No backpressure: a request is accepted every cycle its enable is high. Reads and writes are independent and may occur in the same cycle.
- Write:
  - An in-range write with mem_w_en=1 at edge N updates the array at edge N.
  - An out-of-range write leaves the array unchanged and sets addr_err at edge N.
- Read:
  - A read with mem_r_en=1 at edge N captures a data snapshot at edge N.
  - That data appears on mem_r_data with mem_r_valid=1 during the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1, data is valid in the cycle following the request edge.
  - The pipeline is fully pipelined: back-to-back reads every cycle return back-to-back valids in issue order.
  - Out-of-range read: returns 0 with mem_r_valid=1 at normal latency and sets addr_err.
- Collision: a read and a write to the same in-range address at the same edge is write-first. The read returns mem_w_data.
- Snapshot rule: data is fixed at issue. A write to the same address while a read is in flight does not change the returned value.
- Counters:
  - rd_count increments by 1 per accepted in-range read; wr_count by 1 per accepted in-range write.
  - Both saturate at 2**CNT_WIDTH-1.
  - Out-of-range accesses are not counted.
- addr_err stays at 1 until rst.
- mem_r_data changes only on cycles where mem_r_valid=1, or on reset.
- READ_LATENCY outside 1..4 is a configuration error; elaboration must fail via a generate-time check.

Test Plan:
- Basic write/read, latency 1: write 0x1234 to 0x005, then read 0x005 → mem_r_valid high exactly 1 cycle after the read edge, mem_r_data=0x1234, wr_count=1, rd_count=1.
- Pipelined reads, READ_LATENCY=3: preload addresses 0..3 with 0xA0..0xA3; issue reads on 4 consecutive cycles → 4 consecutive valids starting 3 cycles after the first read, data 0xA0,0xA1,0xA2,0xA3 in order.
- Write-first and snapshot, READ_LATENCY=2:
  - Same-cycle read and write to 0x010 with data 0xBEEF → read returns 0xBEEF.
  - Then read 0x010 and, one cycle later, write 0x0001 to 0x010 → that read still returns 0xBEEF.
- Out-of-range, ADDR_BITS=10:
  - Write 0x5555 to 0x0400 → array unchanged (a read of 0x000 returns its prior value), addr_err=1, wr_count unchanged.
  - Read 0x0400 → valid with data 0, rd_count unchanged, addr_err stays 1.
- Reset mid-flight, READ_LATENCY=4: issue 2 reads, assert rst 2 cycles later → no mem_r_valid is ever produced for them; all outputs are 0 asynchronously; RAM data written before reset is still readable after rst is released.
- Saturation, CNT_WIDTH=4: 20 in-range writes → wr_count reaches 15 and holds there.

Source files
------------

// File: rtl/bb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bb_mem_responder
// Description : Memory-side responder for the black_bean memory port.
//               Word-addressed RAM with a fixed-latency, fully pipelined read
//               path, write-first collision handling, sticky out-of-range
//               flag and saturating access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bb_mem_responder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic [DATA_WIDTH-1:0] mem_r_addr,
  input  logic                  mem_w_en,
  input  logic [DATA_WIDTH-1:0] mem_w_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  output logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  mem_r_valid,
  output logic                  addr_err,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int                   c_DEPTH   = 2 ** ADDR_BITS;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  // Storage is deliberately left out of reset so contents survive rst.
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic [ADDR_BITS-1:0]  w_rd_idx;
  logic [ADDR_BITS-1:0]  w_wr_idx;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_snap_data;
  logic                  w_snap_valid;
  logic [DATA_WIDTH-1:0] w_last_data;
  logic                  w_last_valid;
  logic                  w_rd_accept;
  logic                  w_wr_accept;

  // An address is legal only when every bit above the array index is zero.
  assign w_rd_in_range = (mem_r_addr[DATA_WIDTH-1:ADDR_BITS] == '0);
  assign w_wr_in_range = (mem_w_addr[DATA_WIDTH-1:ADDR_BITS] == '0);
  assign w_rd_idx      = mem_r_addr[ADDR_BITS-1:0];
  assign w_wr_idx      = mem_w_addr[ADDR_BITS-1:0];
  assign w_rd_accept   = mem_r_en && w_rd_in_range;
  assign w_wr_accept   = mem_w_en && w_wr_in_range;

  // Same-edge write to the read address wins: the read sees the new data.
  assign w_collide     = w_wr_accept && w_rd_in_range && (mem_w_addr == mem_r_addr);
  assign w_snap_valid  = mem_r_en;

  // Read snapshot taken at issue; out-of-range reads return zero.
  always_comb begin
    w_snap_data = '0;
    if (w_rd_in_range) begin
      w_snap_data = w_collide ? mem_w_data : r_mem[w_rd_idx];
    end
  end

  // RAM write port; out-of-range writes are discarded.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[w_wr_idx] <= mem_w_data;
    end
  end

  // The output register is the final latency stage, so READ_LATENCY-1
  // intermediate stages sit between the snapshot and the output.
  generate
    if ((READ_LATENCY < 1) || (READ_LATENCY > 4) || (ADDR_BITS >= DATA_WIDTH)) begin : g_bad_config
      $fatal(1, "bb_mem_responder: READ_LATENCY must be 1..4 and ADDR_BITS < DATA_WIDTH");
    end else if (READ_LATENCY == 1) begin : g_no_pipe
      assign w_last_valid = w_snap_valid;
      assign w_last_data  = w_snap_data;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0]   r_pipe_data [READ_LATENCY-1];
      logic [READ_LATENCY-2:0] r_pipe_valid;

      // Shift snapshots toward the output; reset drops reads in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe_valid <= '0;
          for (int i = 0; i < READ_LATENCY - 1; i++) begin
            r_pipe_data[i] <= '0;
          end
        end else begin
          r_pipe_valid[0] <= w_snap_valid;
          r_pipe_data[0]  <= w_snap_data;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            r_pipe_valid[i] <= r_pipe_valid[i-1];
            r_pipe_data[i]  <= r_pipe_data[i-1];
          end
        end
      end

      assign w_last_valid = r_pipe_valid[READ_LATENCY-2];
      assign w_last_data  = r_pipe_data[READ_LATENCY-2];
    end
  endgenerate

  // Output stage: valid is a single-cycle pulse, data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r_valid <= 1'b0;
      mem_r_data  <= '0;
    end else begin
      mem_r_valid <= w_last_valid;
      if (w_last_valid) begin
        mem_r_data <= w_last_data;
      end
    end
  end

  // Sticky error flag for any out-of-range read or write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if ((mem_r_en && !w_rd_in_range) || (mem_w_en && !w_wr_in_range)) begin
      addr_err <= 1'b1;
    end
  end

  // Saturating counters of accepted in-range accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (w_rd_accept && (rd_count != c_CNT_MAX)) begin
        rd_count <= rd_count + 1'b1;
      end
      if (w_wr_accept && (wr_count != c_CNT_MAX)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bb_mem_responder
// Description : Self-checking bench for bb_mem_responder. Four instances with
//               read latencies 1..4 share one stimulus stream; the latency-2
//               instance uses 4-bit counters for the saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bb_mem_responder;

  logic        clk;
  logic        rst;
  logic        r_en;
  logic [15:0] r_addr;
  logic        w_en;
  logic [15:0] w_addr;
  logic [15:0] w_data;

  logic [15:0] d1, d2, d3, d4;
  logic        v1, v2, v3, v4;
  logic        e1, e2, e3, e4;
  logic [15:0] rc1, wc1, rc3, wc3, rc4, wc4;
  logic [3:0]  rc2, wc2;

  int checks = 0;
  int errors = 0;

  bb_mem_responder #(.DATA_WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(1), .CNT_WIDTH(16)) u_l1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_r_addr(r_addr), .mem_w_en(w_en),
    .mem_w_addr(w_addr), .mem_w_data(w_data), .mem_r_data(d1), .mem_r_valid(v1),
    .addr_err(e1), .rd_count(rc1), .wr_count(wc1));

  bb_mem_responder #(.DATA_WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(2), .CNT_WIDTH(4)) u_l2 (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_r_addr(r_addr), .mem_w_en(w_en),
    .mem_w_addr(w_addr), .mem_w_data(w_data), .mem_r_data(d2), .mem_r_valid(v2),
    .addr_err(e2), .rd_count(rc2), .wr_count(wc2));

  bb_mem_responder #(.DATA_WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(3), .CNT_WIDTH(16)) u_l3 (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_r_addr(r_addr), .mem_w_en(w_en),
    .mem_w_addr(w_addr), .mem_w_data(w_data), .mem_r_data(d3), .mem_r_valid(v3),
    .addr_err(e3), .rd_count(rc3), .wr_count(wc3));

  bb_mem_responder #(.DATA_WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(4), .CNT_WIDTH(16)) u_l4 (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_r_addr(r_addr), .mem_w_en(w_en),
    .mem_w_addr(w_addr), .mem_w_data(w_data), .mem_r_data(d4), .mem_r_valid(v4),
    .addr_err(e4), .rd_count(rc4), .wr_count(wc4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [15:0] ra;
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        ev;
    logic [15:0] ed;
    logic        ee;
    logic [15:0] erc;
    logic [15:0] ewc;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic re, input logic [15:0] ra, input logic we,
                       input logic [15:0] wa, input logic [15:0] wd);
    r_en   = re;
    r_addr = ra;
    w_en   = we;
    w_addr = wa;
    w_data = wd;
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //       re    ra        we    wa        wd        ev    ed        ee    rc  wc
    vt[0]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, 1'b0, 0, 1};
    vt[1]  = '{1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 1, 1};
    vt[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0, 1, 1};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0000, 16'h00A0, 1'b0, 16'h1234, 1'b0, 1, 2};
    vt[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 16'h00A1, 1'b0, 16'h1234, 1'b0, 1, 3};
    vt[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 16'h00A2, 1'b0, 16'h1234, 1'b0, 1, 4};
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0003, 16'h00A3, 1'b0, 16'h1234, 1'b0, 1, 5};
    vt[7]  = '{1'b1, 16'h0010, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 2, 6};
    vt[8]  = '{1'b0, 16'h0000, 1'b1, 16'h0400, 16'h5555, 1'b0, 16'hBEEF, 1'b1, 2, 6};
    vt[9]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00A0, 1'b1, 3, 6};
    vt[10] = '{1'b1, 16'h0400, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 3, 6};
    vt[11] = '{1'b1, 16'h0002, 1'b1, 16'h0020, 16'h7777, 1'b1, 16'h00A2, 1'b1, 4, 7};
    vt[12] = '{1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777, 1'b1, 5, 7};

    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();

    // Reset state
    chk("rst_data", {16'h0, d1}, 32'h0);
    chk("rst_valid", {31'h0, v1}, 32'h0);
    chk("rst_err", {31'h0, e1}, 32'h0);
    chk("rst_rd", {16'h0, rc1}, 32'h0);
    chk("rst_wr", {16'h0, wc1}, 32'h0);
    rst = 1'b0;
    tick();

    // Table-driven vectors against the latency-1 instance
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].re, vt[i].ra, vt[i].we, vt[i].wa, vt[i].wd);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'h0, v1}, {31'h0, vt[i].ev});
      chk($sformatf("vec%0d_data", i), {16'h0, d1}, {16'h0, vt[i].ed});
      chk($sformatf("vec%0d_err", i), {31'h0, e1}, {31'h0, vt[i].ee});
      chk($sformatf("vec%0d_rd", i), {16'h0, rc1}, {16'h0, vt[i].erc});
      chk($sformatf("vec%0d_wr", i), {16'h0, wc1}, {16'h0, vt[i].ewc});
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) tick();

    // Pipelined reads of 0..3 on the latency-3 instance
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc < 4) drive(1'b1, 16'(cyc), 1'b0, 16'h0, 16'h0);
      else         drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      tick();
      chk($sformatf("pipe%0d_valid", cyc), {31'h0, v3}, {31'h0, (cyc >= 2 && cyc <= 5)});
      if (cyc >= 2 && cyc <= 5)
        chk($sformatf("pipe%0d_data", cyc), {16'h0, d3}, 32'h00A0 + 32'(cyc - 2));
      else if (cyc == 6)
        chk("pipe_hold", {16'h0, d3}, 32'h00A3);
    end

    // Write-first collision and issue-time snapshot on the latency-2 instance
    drive(1'b0, 16'h0, 1'b1, 16'h0010, 16'h1111);
    tick();
    drive(1'b1, 16'h0010, 1'b1, 16'h0010, 16'hBEEF);   // F0
    tick();
    chk("wf_f0_valid", {31'h0, v2}, 32'h0);
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);          // F1
    tick();
    chk("wf_collide_valid", {31'h0, v2}, 32'h1);
    chk("wf_collide_data", {16'h0, d2}, 32'hBEEF);
    drive(1'b0, 16'h0, 1'b1, 16'h0010, 16'h0001);       // F2
    tick();
    chk("snap_valid", {31'h0, v2}, 32'h1);
    chk("snap_data", {16'h0, d2}, 32'hBEEF);
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);          // F3
    tick();
    chk("snap_gap_valid", {31'h0, v2}, 32'h0);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("after_write_valid", {31'h0, v2}, 32'h1);
    chk("after_write_data", {16'h0, d2}, 32'h0001);

    // Reset with reads in flight on the latency-4 instance
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_err4", {31'h0, e4}, 32'h1);
    drive(1'b1, 16'h0005, 1'b0, 16'h0, 16'h0);          // G0
    tick();
    tick();                                             // G1
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();                                             // G2
    chk("pre_rst_valid4", {31'h0, v4}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data4", {16'h0, d4}, 32'h0);
    chk("arst_valid4", {31'h0, v4}, 32'h0);
    chk("arst_err4", {31'h0, e4}, 32'h0);
    chk("arst_rd4", {16'h0, rc4}, 32'h0);
    chk("arst_wr4", {16'h0, wc4}, 32'h0);
    chk("arst_data1", {16'h0, d1}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("dropped%0d_valid4", i), {31'h0, v4}, 32'h0);
    end
    drive(1'b1, 16'h0005, 1'b0, 16'h0, 16'h0);          // H0
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_rst%0d_valid4", i), {31'h0, v4}, 32'h0);
      tick();
    end
    chk("post_rst_valid4", {31'h0, v4}, 32'h1);
    chk("post_rst_data4", {16'h0, d4}, 32'h1234);
    chk("post_rst_rd4", {16'h0, rc4}, 32'h1);

    // Saturating write counter on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 16'h0, 1'b1, 16'h0100 + 16'(i), 16'(i));
      tick();
      chk($sformatf("sat%0d_wr2", i), {28'h0, wc2}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("sat_hold_wr2", {28'h0, wc2}, 32'd15);
    chk("wide_wr1", {16'h0, wc1}, 32'd20);
    chk("wide_rd1", {16'h0, rc1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
